// File: rtl/lane_unpacker_pkg.sv
// Shared types for the lane unpacker: FSM state encoding.
package lane_unpacker_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/lane_unpacker_lane_select.sv
// One-hot AND-OR lane multiplexer: picks lane i_sel out of a packed wide word.
module lane_select #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic [WIDTH*LANES-1:0]   i_data,
  input  logic [$clog2(LANES)-1:0] i_sel,
  output logic [WIDTH-1:0]         o_data
);

  localparam int IDX_W = $clog2(LANES);

  logic [LANES-1:0][WIDTH-1:0] masked_s;

  // Each lane is gated by its own decode of the select index.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic hit_s;
    assign hit_s       = (i_sel == IDX_W'(k));
    assign masked_s[k] = i_data[k*WIDTH +: WIDTH] & {WIDTH{hit_s}};
  end

  // OR-reduce the masked lanes; at most one is non-zero.
  always_comb begin
    o_data = {WIDTH{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      o_data = o_data | masked_s[k];
    end
  end

endmodule

// File: rtl/lane_unpacker.sv
// Wide-to-narrow unpacker: captures one word of LANES lanes and replays
// lanes 0..last_idx as narrow beats, with zero-bubble word chaining.
module lane_unpacker
  import lane_unpacker_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [WIDTH*LANES-1:0] i_data,
  input  logic [IDX_W-1:0]       i_last_idx,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic [IDX_W-1:0]       o_lane,
  output logic                   o_last
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(LANES - 1);

  state_t                 state_r;
  logic [WIDTH*LANES-1:0] hold_r;
  logic [IDX_W-1:0]       cnt_r;
  logic [IDX_W-1:0]       last_r;
  logic [IDX_W-1:0]       last_in_s;
  logic                   last_s;
  logic                   ready_s;
  logic                   accept_s;

  // Indices past the top lane only exist when LANES is not a power of two.
  if ((1 << IDX_W) == LANES) begin : g_no_clamp
    assign last_in_s = i_last_idx;
  end else begin : g_clamp
    assign last_in_s = (i_last_idx > MAX_IDX) ? MAX_IDX : i_last_idx;
  end

  assign last_s   = (state_r == SEND) && (cnt_r == last_r);
  assign accept_s = i_valid && ready_s;

  // Upstream ready: free in IDLE, or in SEND when the final beat is leaving now.
  always_comb begin
    ready_s = 1'b0;
    if (!i_rst_n) begin
      ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    ready_s = 1'b1;
        SEND:    ready_s = last_s && i_ready;
        default: ready_s = 1'b0;
      endcase
    end
  end

  // FSM with hold register, lane counter and last-lane index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      hold_r  <= {(WIDTH*LANES){1'b0}};
      cnt_r   <= {IDX_W{1'b0}};
      last_r  <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            hold_r  <= i_data;
            last_r  <= last_in_s;
            cnt_r   <= {IDX_W{1'b0}};
            state_r <= SEND;
          end
        end
        SEND: begin
          if (i_ready) begin
            if (!last_s) begin
              cnt_r <= cnt_r + IDX_W'(1);
            end else if (accept_s) begin
              hold_r <= i_data;
              last_r <= last_in_s;
              cnt_r  <= {IDX_W{1'b0}};
            end else begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  lane_select #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane_select (
    .i_data (hold_r),
    .i_sel  (cnt_r),
    .o_data (o_data)
  );

  assign o_ready = ready_s;
  assign o_valid = (state_r == SEND);
  assign o_lane  = cnt_r;
  assign o_last  = last_s;

endmodule

// File: doc/lane_unpacker.md
# lane_unpacker

Width-reducing reader stage: accepts one wide word of `LANES` packed lanes over a valid/ready handshake and replays it as up to `LANES` narrow beats, lane 0 first, over a second valid/ready handshake. It is the read-side counterpart to the lane packer in the testcase set and exercises generate-for loops with named per-lane blocks and a small FSM. It sits between a wide source and a narrow sink; back-pressure propagates both ways.

## Interface
- `WIDTH`, default 8: bits per lane (≥1)
- `LANES`, default 4: lanes per wide word (≥2)
- `IDX_W`, default `$clog2(LANES)`: lane index width (derived, not overridden)
- `i_clk`  input  1  clock, rising edge
- `i_rst_n`  input  1  reset, asynchronous, active-low
- `i_valid`  input  1  wide word offered
- `o_ready`  output  1  unpacker can take a wide word
- `i_data`  input  `WIDTH*LANES`  packed word; lane k = bits `[k*WIDTH +: WIDTH]`
- `i_last_idx`  input  `IDX_W`  index of last valid lane (0 → 1 beat, `LANES-1` → all lanes)
- `o_valid`  output  1  narrow beat presented
- `i_ready`  input  1  sink accepts beat
- `o_data`  output  `WIDTH`  current lane
- `o_lane`  output  `IDX_W`  index of current lane
- `o_last`  output  1  current beat is the final lane of the word

## Operation
- States: `IDLE`, `SEND`.
- `IDLE`: `o_ready`=1, `o_valid`=0. On `i_valid && o_ready`: capture `i_data` into hold register, `i_last_idx` into `last_q`, lane counter ← 0, go `SEND`.
- `SEND`: `o_valid`=1; `o_data` = hold lane `o_lane`; `o_last` = (`o_lane == last_q`).
  - `i_ready` && !`o_last`: lane counter +1, stay `SEND`.
  - `i_ready` && `o_last`: word done. If `i_valid` in same cycle (`o_ready`=1 here), capture new word, counter ← 0, stay `SEND` (zero-bubble); else go `IDLE`.
  - `!i_ready`: hold everything; `o_data`, `o_lane`, `o_last` stable.
- `o_ready` = `IDLE` || (`SEND` && `o_last` && `i_ready`); forced 0 while `i_rst_n` low.
- `i_last_idx` > `LANES-1` (non-power-of-two `LANES`): clamped to `LANES-1` at capture.
- Counter never exceeds `last_q`; no wrap within a word.
- `i_data`/`i_last_idx` ignored unless handshake completes.

## Timing
- Reset (async assert, sync release): state `IDLE`, hold register 0, counter 0, `last_q` 0. Outputs during/after reset: `o_valid`=0, `o_data`=0, `o_lane`=0, `o_last`=0, `o_ready`=0 during reset, 1 first cycle after release.
- Latency: lane 0 valid the cycle after wide accept.
- Throughput: `last_idx+1` cycles per word with `i_ready` held high; no bubble between words.
- `o_ready` combinational from `i_ready` in `SEND`; `o_valid`/`o_data`/`o_lane`/`o_last` depend only on registers (no input→`o_valid` path).
- Reset mid-word: word discarded, no further beats, `o_valid` drops asynchronously.

## Structure
- Package `lane_unpacker_pkg`: state enum `state_t` {`IDLE`, `SEND`}.
- Sub-module `lane_select`: params `WIDTH`, `LANES`; purely combinational one-hot AND-OR lane mux built with a generate-for over lanes, each iteration a named block; output is `o_data`.
- Top holds FSM, hold register, counter, `last_q`.

## Test plan
- Reset: hold `i_rst_n`=0 with `i_valid`=1 → `o_ready`=0, `o_valid`=0, `o_data`=0; release → `o_ready`=1 next cycle.
- Full word: `i_data`=0x44332211, `i_last_idx`=3, `i_ready`=1 → beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles, `o_lane` 0..3, `o_last` only on 0x44.
- Short word + back-to-back: word A (`last_idx`=1, 0xBBAA) then B (`last_idx`=0, 0xCC) offered continuously → AA, BB, CC on 3 consecutive cycles; B accepted in same cycle as BB.
- Back-pressure: `i_ready` low 3 cycles during lane 2 → `o_data`=0x33, `o_lane`=2 held stable; `o_ready`=0 throughout.
- Reset mid-word: assert `i_rst_n`=0 after lane 1 → `o_valid` 0 immediately; after release, next word starts at lane 0 with new data.
